// File: rtl/matmul_seq_ctrl_if.sv
// matmul_seq_ctrl_if: memory and transmit bundle of the matmul sequencer.
// master = sequencer side, slave = memories and UART transmit block.
interface matmul_seq_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 8
);
  logic              a_read;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_read;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [ACC_W-1:0]  r_value;
  logic              tx_req;
  logic              tx_busy;
  logic              tx_done;

  modport master (
    output a_read,
    output a_addr,
    input  a_data,
    output b_read,
    output b_addr,
    input  b_data,
    output r_write,
    output r_addr,
    output r_value,
    output tx_req,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  a_read,
    input  a_addr,
    output a_data,
    input  b_read,
    input  b_addr,
    output b_data,
    input  r_write,
    input  r_addr,
    input  r_value,
    input  tx_req,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: walks R = A x B through a single MAC,
// writes R row-major, then hands R to the UART transmitter.
module matmul_seq_ctrl #(
  parameter int ROW    = 2,
  parameter int INNER  = 2,
  parameter int COL    = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  matmul_seq_ctrl_if.master bus
);

  localparam int IW = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int KW = (INNER > 1) ? $clog2(INNER) : 1;
  localparam int JW = (COL > 1) ? $clog2(COL) : 1;
  localparam int PW = 2 * DATA_W;

  localparam logic [IW-1:0] I_LAST = IW'(ROW - 1);
  localparam logic [KW-1:0] K_LAST = KW'(INNER - 1);
  localparam logic [JW-1:0] J_LAST = JW'(COL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MAC,
    S_WRITE,
    S_TX_START,
    S_TX_WAIT,
    S_DONE
  } state_t;

  state_t state;

  logic [IW-1:0]    i;
  logic [KW-1:0]    k;
  logic [JW-1:0]    j;
  logic [ACC_W-1:0] acc;

  logic [IW-1:0]    i_nxt;
  logic [KW-1:0]    k_nxt;
  logic [JW-1:0]    j_nxt;
  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] acc_nxt;
  logic             k_last;
  logic             last_elem;

  function automatic logic [ADDR_W-1:0] a_at(
    input logic [IW-1:0] ii,
    input logic [KW-1:0] kk
  );
    return ADDR_W'(ii) * ADDR_W'(INNER)
         + ADDR_W'(kk);
  endfunction

  function automatic logic [ADDR_W-1:0] b_at(
    input logic [KW-1:0] kk,
    input logic [JW-1:0] jj
  );
    return ADDR_W'(kk) * ADDR_W'(COL)
         + ADDR_W'(jj);
  endfunction

  function automatic logic [ADDR_W-1:0] r_at(
    input logic [IW-1:0] ii,
    input logic [JW-1:0] jj
  );
    return ADDR_W'(ii) * ADDR_W'(COL)
         + ADDR_W'(jj);
  endfunction

  // Next loop indices (j fastest) and the MAC result.
  always_comb begin
    k_nxt     = k + 1'b1;
    i_nxt     = i;
    j_nxt     = j + 1'b1;
    if (j == J_LAST) begin
      i_nxt = i + 1'b1;
      j_nxt = '0;
    end
    k_last    = (k == K_LAST);
    last_elem = (i == I_LAST) && (j == J_LAST);
    prod      = PW'(bus.a_data) * PW'(bus.b_data);
    if (k == '0) begin
      acc_nxt = ACC_W'(prod);
    end else begin
      acc_nxt = acc + ACC_W'(prod);
    end
  end

  // Sequencer FSM; every output is a register set
  // on the edge that enters the state showing it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bus.a_read  <= 1'b0;
      bus.b_read  <= 1'b0;
      bus.r_write <= 1'b0;
      bus.tx_req  <= 1'b0;
      bus.a_addr  <= '0;
      bus.b_addr  <= '0;
      bus.r_addr  <= '0;
      bus.r_value <= '0;
    end else if (abort) begin
      state       <= S_IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bus.a_read  <= 1'b0;
      bus.b_read  <= 1'b0;
      bus.r_write <= 1'b0;
      bus.tx_req  <= 1'b0;
    end else begin
      bus.a_read  <= 1'b0;
      bus.b_read  <= 1'b0;
      bus.r_write <= 1'b0;
      bus.tx_req  <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            i          <= '0;
            j          <= '0;
            k          <= '0;
            busy       <= 1'b1;
            bus.a_read <= 1'b1;
            bus.b_read <= 1'b1;
            bus.a_addr <= a_at('0, '0);
            bus.b_addr <= b_at('0, '0);
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_MAC;
        end
        S_MAC: begin
          acc <= acc_nxt;
          if (k_last) begin
            bus.r_write <= 1'b1;
            bus.r_addr  <= r_at(i, j);
            bus.r_value <= acc_nxt;
            state       <= S_WRITE;
          end else begin
            k          <= k_nxt;
            bus.a_read <= 1'b1;
            bus.b_read <= 1'b1;
            bus.a_addr <= a_at(i, k_nxt);
            bus.b_addr <= b_at(k_nxt, j);
            state      <= S_FETCH;
          end
        end
        S_WRITE: begin
          k <= '0;
          if (last_elem) begin
            i     <= '0;
            j     <= '0;
            // Launch at once when the link is idle.
            bus.tx_req <= !bus.tx_busy;
            state      <= S_TX_START;
          end else begin
            i          <= i_nxt;
            j          <= j_nxt;
            bus.a_read <= 1'b1;
            bus.b_read <= 1'b1;
            bus.a_addr <= a_at(i_nxt, '0);
            bus.b_addr <= b_at('0, j_nxt);
            state      <= S_FETCH;
          end
        end
        S_TX_START: begin
          // The pulse already shown ends the wait.
          if (bus.tx_req) begin
            state <= S_TX_WAIT;
          end else if (!bus.tx_busy) begin
            bus.tx_req <= 1'b1;
          end
        end
        S_TX_WAIT: begin
          if (bus.tx_done) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl: random and directed products
// checked through queue scoreboards by a negedge monitor.
module tb_matmul_seq_ctrl;

  localparam int ROW      = 2;
  localparam int INNER    = 2;
  localparam int COL      = 2;
  localparam int DATA_W   = 8;
  localparam int ACC_W    = 16;
  localparam int ADDR_W   = 8;
  localparam int ELEM_CYC = 2 * INNER + 1;

  typedef struct { int a; int b; } rd_t;
  typedef struct { int addr; int val; } wr_t;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic done;

  matmul_seq_ctrl_if #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .ADDR_W(ADDR_W)
  ) bus ();

  matmul_seq_ctrl #(
    .ROW   (ROW),
    .INNER (INNER),
    .COL   (COL),
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .abort(abort),
    .busy (busy),
    .done (done),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] amem [256];
  logic [DATA_W-1:0] bmem [256];
  int ma [ROW][INNER];
  int mb [INNER][COL];

  rd_t rd_q[$];
  wr_t wr_q[$];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int tx_cnt = 0;
  int done_cnt = 0;
  int tx_pulses = 0;
  int start_cyc = 0;
  int last_wr_cyc = 0;
  int exp_tx_cyc = -1;
  int exp_done_cyc = -1;
  bit first_wr = 1'b1;
  bit prev_done = 1'b0;

  task automatic chk(input string nm,
                     input longint got,
                     input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, got, want, cyc);
    end
  endtask

  // Synchronous-read operand memories.
  always @(posedge clk) begin
    if (!rst) begin
      bus.a_data <= '0;
      bus.b_data <= '0;
    end else begin
      if (bus.a_read) bus.a_data <= amem[bus.a_addr];
      if (bus.b_read) bus.b_data <= bmem[bus.b_addr];
    end
  end

  // Transmitter model: answers each tx_req with tx_done.
  initial begin : tx_model
    int lat;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && bus.tx_req) begin
        lat = $urandom_range(1, 4);
        repeat (lat) @(posedge clk);
        #1 bus.tx_done = 1'b1;
        exp_done_cyc = cyc + 1;
        @(posedge clk);
        #1 bus.tx_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboards whenever the DUT acts.
  initial begin : monitor
    rd_t r;
    wr_t w;
    int nstrb;
    forever begin
      @(negedge clk);
      if (rst) begin
        nstrb = int'(bus.a_read) + int'(bus.r_write)
              + int'(bus.tx_req);
        chk("strobe_excl",
            (nstrb <= 1) && (bus.a_read == bus.b_read), 1);
        if (prev_done) begin
          chk("busy_after_done", busy, 0);
          chk("done_width", done, 0);
          prev_done = 1'b0;
        end
        if (bus.a_read) begin
          if (rd_q.size() == 0) begin
            chk("unexpected_read", 1, 0);
          end else begin
            r = rd_q.pop_front();
            chk("a_addr", bus.a_addr, r.a);
            chk("b_addr", bus.b_addr, r.b);
          end
        end
        if (bus.r_write) begin
          wr_cnt++;
          if (wr_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            w = wr_q.pop_front();
            chk("r_addr", bus.r_addr, w.addr);
            chk("r_value", bus.r_value, w.val);
            chk("busy_in_write", busy, 1);
            if (first_wr) begin
              chk("first_write_lat",
                  cyc - start_cyc + 1, ELEM_CYC);
            end else begin
              chk("write_spacing",
                  cyc - last_wr_cyc, ELEM_CYC);
            end
            first_wr = 1'b0;
            last_wr_cyc = cyc;
            if (wr_q.size() == 0) begin
              exp_tx_cyc = bus.tx_busy ? -1 : cyc + 1;
            end
          end
        end
        if (bus.tx_req) begin
          tx_cnt++;
          tx_pulses++;
          chk("tx_req_cycle", cyc, exp_tx_cyc);
        end
        if (done) begin
          done_cnt++;
          chk("done_cycle", cyc, exp_done_cyc);
          chk("busy_at_done", busy, 1);
          prev_done = 1'b1;
        end
      end
    end
  end

  // Reference: R[i][j] = sum_k A[i][k]*B[k][j] mod 2^ACC_W.
  task automatic push_model();
    int s;
    for (int i = 0; i < ROW; i++)
      for (int k = 0; k < INNER; k++)
        amem[i*INNER+k] = DATA_W'(ma[i][k]);
    for (int k = 0; k < INNER; k++)
      for (int j = 0; j < COL; j++)
        bmem[k*COL+j] = DATA_W'(mb[k][j]);
    for (int i = 0; i < ROW; i++) begin
      for (int j = 0; j < COL; j++) begin
        s = 0;
        for (int k = 0; k < INNER; k++) begin
          s += ma[i][k] * mb[k][j];
          rd_q.push_back('{a: i*INNER+k, b: k*COL+j});
        end
        wr_q.push_back('{addr: i*COL+j,
                         val: s % (1 << ACC_W)});
      end
    end
    first_wr   = 1'b1;
    tx_pulses  = 0;
    exp_tx_cyc = -1;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < ROW; i++)
      for (int k = 0; k < INNER; k++)
        ma[i][k] = $urandom_range(0, 255);
    for (int k = 0; k < INNER; k++)
      for (int j = 0; j < COL; j++)
        mb[k][j] = $urandom_range(0, 255);
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < ROW; i++)
      for (int k = 0; k < INNER; k++)
        ma[i][k] = v;
    for (int k = 0; k < INNER; k++)
      for (int j = 0; j < COL; j++)
        mb[k][j] = v;
  endtask

  task automatic fill_directed();
    ma[0][0] = 1; ma[0][1] = 2;
    ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6;
    mb[1][0] = 7; mb[1][1] = 8;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic run_mul(input bit hold, input bit extra);
    int d0;
    int w0;
    int guard;
    push_model();
    bus.tx_busy = hold;
    w0 = wr_cnt;
    d0 = done_cnt;
    pulse_start();
    if (extra) begin
      repeat (7) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    if (hold) begin
      guard = 0;
      while (wr_cnt != w0 + ROW*COL && guard < 2000) begin
        @(posedge clk);
        guard++;
      end
      repeat (10) @(posedge clk);
      #1 bus.tx_busy = 1'b0;
      exp_tx_cyc = cyc + 1;
    end
    guard = 0;
    while (done_cnt == d0 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    chk("done_seen", done_cnt - d0, 1);
    repeat (2) @(posedge clk);
    chk("tx_pulses", tx_pulses, 1);
    chk("writes_left", wr_q.size(), 0);
    chk("reads_left", rd_q.size(), 0);
    rd_q.delete();
    wr_q.delete();
  endtask

  task automatic abort_test();
    int n;
    int guard;
    int w0;
    int t0;
    int d0;
    fill_rand();
    push_model();
    pulse_start();
    n = 0;
    guard = 0;
    while (n < 3 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (bus.a_read) n++;
    end
    chk("abort_reach_mac3", n, 3);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    rd_q.delete();
    wr_q.delete();
    chk("abort_busy", busy, 0);
    w0 = wr_cnt;
    t0 = tx_cnt;
    d0 = done_cnt;
    repeat (20) @(posedge clk);
    chk("abort_no_write", wr_cnt - w0, 0);
    chk("abort_no_tx_req", tx_cnt - t0, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle_busy", busy, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_a_read"}, bus.a_read, 0);
    chk({tag, "_b_read"}, bus.b_read, 0);
    chk({tag, "_r_write"}, bus.r_write, 0);
    chk({tag, "_tx_req"}, bus.tx_req, 0);
    chk({tag, "_a_addr"}, bus.a_addr, 0);
    chk({tag, "_b_addr"}, bus.b_addr, 0);
    chk({tag, "_r_addr"}, bus.r_addr, 0);
    chk({tag, "_r_value"}, bus.r_value, 0);
  endtask

  task automatic reset_test();
    int guard;
    fill_rand();
    push_model();
    pulse_start();
    guard = 0;
    while (!bus.r_write && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_reach_write", bus.r_write, 1);
    #1 rst = 1'b0;
    #1 check_zero("midrst");
    rd_q.delete();
    wr_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin : stim
    bus.tx_busy = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b1;

    fill_directed();
    run_mul(1'b0, 1'b0);

    fill_const(255);
    run_mul(1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      fill_rand();
      run_mul(1'b0, 1'b0);
    end

    fill_rand();
    run_mul(1'b1, 1'b0);

    abort_test();
    fill_directed();
    run_mul(1'b0, 1'b0);

    reset_test();
    fill_rand();
    run_mul(1'b0, 1'b1);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencer for the matrix-multiply datapath: R = A x B.
- Drives read ports of operand memories A and B, runs a single MAC, and writes each result element into the R memory in row-major order.
- When R is complete, requests serial transmission of R from the memory-to-UART transmit block and waits for it to finish.
- Sits between the top-level control/buttons and the memory/transmit blocks.

Parameters:
- ROW, 2, rows of A and R
- INNER, 2, columns of A = rows of B
- COL, 2, columns of B and R
- DATA_W, 8, width of A/B elements (unsigned)
- ACC_W, 16, width of R elements and accumulator
- ADDR_W, 8, width of every memory address port

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  level; sampled only in IDLE; begins a multiply
- abort  in  1  synchronous; returns FSM to IDLE next edge from any state
- a_read  out  1  read strobe to A memory
- a_addr  out  ADDR_W  A address = i*INNER+k
- a_data  in  DATA_W  A read data, valid the cycle after a_read
- b_read  out  1  read strobe to B memory
- b_addr  out  ADDR_W  B address = k*COL+j
- b_data  in  DATA_W  B read data, valid the cycle after b_read
- r_write  out  1  single-cycle write strobe to R memory
- r_addr  out  ADDR_W  R address = i*COL+j
- r_value  out  ACC_W  result element
- tx_req  out  1  one-cycle pulse: transmit R
- tx_busy  in  1  transmitter busy
- tx_done  in  1  one-cycle pulse: transmit of R finished
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion

Behaviour:
- Reset (rst=0): state IDLE; i, j, k, acc = 0; all strobes, tx_req, busy, done = 0; addresses and r_value = 0.
- States: IDLE, FETCH, MAC, WRITE, TX_START, TX_WAIT, DONE. All outputs are registered.
- IDLE: if start=1 then clear i, j, k and go to FETCH. Otherwise stay.
- FETCH, one cycle:
  - a_read = b_read = 1, with addresses for the current (i, j, k).
  - Go to MAC.
- MAC, one cycle:
  - Product = a_data*b_data, 2*DATA_W bits.
  - acc <= product when k=0; otherwise acc <= acc+product.
  - Arithmetic is unsigned and truncated modulo 2^ACC_W. No saturation, no overflow flag.
  - If k = INNER-1, go to WRITE. Otherwise k++ and go to FETCH.
- WRITE, one cycle:
  - r_write = 1, r_addr = i*COL+j, r_value = acc.
  - Then k = 0 and (i, j) advance with j fastest: j wraps at COL-1 and i++.
  - After the element (ROW-1, COL-1) is written, go to TX_START. Otherwise go to FETCH.
- Latency:
  - Each element takes 2*INNER+1 cycles.
  - The first r_write is high in cycle 2*INNER+1 after the edge that samples start.
  - Total compute time is ROW*COL*(2*INNER+1) cycles.
- TX_START:
  - Wait while tx_busy = 1.
  - When tx_busy = 0, pulse tx_req for exactly one cycle and go to TX_WAIT.
- TX_WAIT: wait for tx_done, then go to DONE. tx_done in any other state is ignored.
- DONE: done = 1 for one cycle, then IDLE.
- start is ignored outside IDLE. A start still high in IDLE after DONE begins a new multiply (level-sensitive by design).
- abort has priority over every transition:
  - Next edge goes to IDLE, with no done, no further strobes, and a cleared accumulator.
  - R may hold a partial result.
  - Abort while tx_req is high still leaves that one pulse emitted.
- Reset mid-operation is equivalent to abort, but asynchronous.
- Strobes are never asserted concurrently with each other: reads, write and tx_req are mutually exclusive.

Test Plan:
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulse -> r_write at addr 0,1,2,3 with values 19,22,43,50; first write 5 cycles after start edge, writes 5 cycles apart; tx_req one cycle after last write; tx_done -> done one cycle later, busy falls with it.
- Address sequence check for the same run -> a_addr 0,1,0,1,2,3,2,3 and b_addr 0,2,1,3,0,2,1,3 on the eight read pairs per pass.
- All A and B elements = 255 -> every r_value = 130050 mod 65536 = 64514.
- tx_busy held 1 for 10 cycles on entering TX_START -> tx_req asserted only on the first cycle after tx_busy falls, exactly one pulse.
- abort asserted during the third MAC -> IDLE next edge, busy=0, no further r_write/tx_req/done; a subsequent start gives correct full results.
- rst low during WRITE -> all outputs 0 immediately; start pulse while busy is ignored (no restart, results unchanged).
